// File: rtl/spad_pkg.sv
// +------------------------------------------------------------------------+
// | spad_pkg                                                               |
// | Shared scratchpad widths and read-sequencer state encoding.            |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

package spad_pkg;

  localparam int SPAD_DATA_WIDTH    = 16;
  localparam int SPAD_ADDR_BITWIDTH = 9;
  localparam int SPAD_LEN_BITWIDTH  = SPAD_ADDR_BITWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } spad_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/spad_rd_fifo2.sv
// +------------------------------------------------------------------------+
// | spad_rd_fifo2                                                          |
// | Two-entry {data,last} FIFO; push and pop may coincide, order is kept.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module spad_rd_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] data_q [2];
  logic [1:0]       last_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != 2'd2) || pop_i);
  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = last_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/spad_read_streamer.sv
// +------------------------------------------------------------------------+
// | spad_read_streamer                                                     |
// | Burst read sequencer: SPad reads -> valid/ready stream with last flag. |
// | Optional SPAD_RD_STRIDE_EN adds the i_stride port (default stride 1).  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module spad_read_streamer
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH    = SPAD_DATA_WIDTH,
  parameter int ADDR_BITWIDTH = SPAD_ADDR_BITWIDTH,
  parameter int LEN_BITWIDTH  = SPAD_LEN_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [ADDR_BITWIDTH-1:0] i_base_addr,
  input  logic [LEN_BITWIDTH-1:0]  i_len,
`ifdef SPAD_RD_STRIDE_EN
  input  logic [ADDR_BITWIDTH-1:0] i_stride,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_spad_ren,
  output logic [ADDR_BITWIDTH-1:0] o_spad_raddr,
  input  logic [DATA_WIDTH-1:0]    i_spad_rdata,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  input  logic                     i_ready
);

  spad_rd_state_t           state_q;
  logic                     busy_q, done_q;
  logic [ADDR_BITWIDTH-1:0] addr_q, stride;
  logic [LEN_BITWIDTH-1:0]  len_q, issued_q;
  logic                     inflight_q, inflight_last_q;

  logic                     fifo_valid, fifo_last;
  logic [DATA_WIDTH-1:0]    fifo_data;
  logic [1:0]               fifo_count;
  logic                     pop, ren, issue_last;
  logic [2:0]               occupancy;

`ifdef SPAD_RD_STRIDE_EN
  logic [ADDR_BITWIDTH-1:0] stride_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stride_q <= '0;
    end else if ((state_q == IDLE) && i_start) begin
      stride_q <= i_stride;
    end
  end

  assign stride = stride_q;
`else
  assign stride = ADDR_BITWIDTH'(1);
`endif

  assign pop = fifo_valid & i_ready;

  // Slots committed once this cycle's pop leaves: buffered words plus the one
  // returning from the SPad now. A new read lands two edges later, so one free
  // slot suffices, which keeps a 1 word/cycle stream under steady i_ready.
  assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign ren        = (state_q == RUN) && (occupancy < 3'd2);
  assign issue_last = ((issued_q + LEN_BITWIDTH'(1)) == len_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= ren;
      inflight_last_q <= ren && issue_last;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            len_q    <= i_len;
            addr_q   <= i_base_addr;
            issued_q <= '0;
            busy_q   <= 1'b1;
            if (i_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (ren) begin
            addr_q   <= addr_q + stride;
            issued_q <= issued_q + LEN_BITWIDTH'(1);
            if (issue_last) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && fifo_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spad_rd_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (i_spad_rdata),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .last_o      (fifo_last),
    .count_o     (fifo_count)
  );

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_spad_ren   = ren;
  assign o_spad_raddr = addr_q;
  assign o_valid      = fifo_valid;
  assign o_data       = fifo_data;
  assign o_last       = fifo_valid & fifo_last;

endmodule

`default_nettype wire
